cdc_fifo_read_ctrl: RTL and testbench
=====================================

Name: cdc_fifo_read_ctrl

Overview:
Parametrised read-domain controller for the next-generation dual-clock FIFO. It replaces the combinational-read/empty-flag read side with the following:
- full-depth pointers (extra wrap bit, so all 2^ADDRESS_WIDTH entries are usable)
- a configurable-depth pointer synchronizer
- a first-word-fall-through output register with valid/ready handshake
- occupancy level, almost-empty flag and a sticky protocol-error flag

It drives the read port of the existing async-read dual-port RAM and exports a registered gray read pointer to the write domain.

Parameters:
DATA_WIDTH, 8, width of each FIFO word
ADDRESS_WIDTH, 4, RAM address bits; DEPTH = 2^ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits
SYNC_STAGES, 2, flop stages on the incoming write pointer; legal range 2..4
ALMOST_EMPTY_THRESHOLD, 2, almost_empty asserts when level <= this value

Ports:
clock  input  1  read-domain clock
reset  input  1  asynchronous, active-high reset, read domain
write_pointer_gray  input  ADDRESS_WIDTH+1  gray write pointer from the write domain (asynchronous to clock)
read_pointer_gray  output  ADDRESS_WIDTH+1  registered gray read pointer, to the write domain
ram_address  output  ADDRESS_WIDTH  RAM read address = rptr[ADDRESS_WIDTH-1:0]
ram_data  input  DATA_WIDTH  RAM read data, combinational from ram_address
read_data  output  DATA_WIDTH  output-register word
read_valid  output  1  read_data holds a valid word
read_ready  input  1  consumer accepts read_data this cycle
empty  output  1  equals !read_valid
almost_empty  output  1  level <= ALMOST_EMPTY_THRESHOLD
level  output  ADDRESS_WIDTH+2  words held: RAM words plus output register, 0..DEPTH+1
protocol_error  output  1  sticky; RAM occupancy exceeded DEPTH

Behaviour:
Reset (asynchronous, immediate):
- All synchronizer flops, rptr, read_pointer_gray, read_data, read_valid and protocol_error go to 0.
- Consequently empty=1 and level=0; almost_empty=1 because 0 <= threshold.

Synchronizer:
- write_pointer_gray passes through SYNC_STAGES flops to give wsync_gray.
- wsync_gray is gray-decoded combinationally to wsync_bin.

Occupancy and level:
- mem_count = (wsync_bin - rptr) mod 2^(ADDRESS_WIDTH+1), unsigned, range 0..DEPTH.
- level = mem_count + read_valid, zero-extended to ADDRESS_WIDTH+2 bits.

Handshake:
- consume = read_valid & read_ready.
- read_ready while !read_valid is legal and has no effect.

Load (FWFT):
- Condition: mem_count != 0 and (!read_valid or consume).
- On load: read_data <= ram_data; rptr <= rptr+1; read_pointer_gray <= bin2gray(rptr+1); read_valid <= 1.
- read_pointer_gray is assigned directly from a flop; no combinational logic on the crossing path.

Hold and drain:
- consume with mem_count == 0: read_valid <= 0; read_data holds its last value.
- No load and no consume: all state holds.
- Sustained throughput is one word per clock when RAM is non-empty and read_ready=1.

Latency:
- A write-pointer change is visible in mem_count after SYNC_STAGES read clocks.
- read_valid rises on the following edge.
- First-word latency from a stable write_pointer_gray to read_valid is SYNC_STAGES+1 clocks.

Wrap-around:
- rptr wraps from 2^(ADDRESS_WIDTH+1)-1 to 0.
- ram_address wraps every DEPTH reads.
- The modular subtraction keeps mem_count correct across wraps.

Full RAM:
- mem_count == DEPTH is legal.
- The write side computes full from read_pointer_gray, so total capacity is DEPTH+1 including the output register.

protocol_error:
- Set when mem_count > DEPTH on any clock (corrupted or non-gray write pointer).
- Stays set until reset. It does not block operation.

Reset mid-operation:
- Discards the output word and all RAM contents logically (rptr=0).
- The write domain must be reset in the same window. Order and overlap of the two resets are not this block's concern.

Test Plan:
1. Reset: assert reset with stimulus active -> immediately read_valid=0, empty=1, almost_empty=1, level=0, read_pointer_gray=0, protocol_error=0.
2. First-word latency (DW=8, AW=4, SYNC_STAGES=2): write_pointer_gray 0->1 with RAM[0]=0xA5 -> read_valid=1 and read_data=0xA5 exactly 3 clocks later; read_pointer_gray=1, level=1.
3. Fill and backpressure: write_pointer_gray=gray(16), read_ready=0 -> level settles at 16; read_valid=1, read_data=RAM[0], rptr=1, level=16; state holds for 50 clocks.
4. Streaming with wrap: read_ready=1, RAM[i]=i, write pointer advanced to 40 over time -> words 0..39 emerge in order at one per clock while data is available; ram_address wraps 15->0 twice; read_pointer_gray=gray(40) at end; empty=1.
5. Thresholds: level stepped 4->0 -> almost_empty rises when level reaches 2 and stays high through 0; empty=1 only at level 0.
6. Error and recovery: write_pointer_gray=gray(20) with rptr=0 -> protocol_error=1 and remains 1 after the pointer is corrected; reset mid-stream (read_valid=1) -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/cdc_fifo_read_ctrl.sv
// Read-domain controller for the dual-clock FIFO.
// Synchronizes the write pointer and presents words through a FWFT output register.
module cdc_fifo_read_ctrl #(
  parameter int DATA_WIDTH             = 8,
  parameter int ADDRESS_WIDTH          = 4,
  parameter int SYNC_STAGES            = 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  output logic [ADDRESS_WIDTH:0]   read_pointer_gray,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH+1:0] level,
  output logic                     protocol_error
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam int LW = ADDRESS_WIDTH + 2;
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDRESS_WIDTH;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wsync_gray;
  logic [PW-1:0] wsync_bin;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rptr_next;
  logic [PW-1:0] mem_count;
  logic          consume;
  logic          load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= write_pointer_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wsync_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    wsync_bin = '0;
    for (int i = 0; i < PW; i++) begin
      wsync_bin[i] = ^(wsync_gray >> i);
    end
  end

  // Modular difference stays correct across pointer wrap.
  assign mem_count = wsync_bin - rptr;
  assign rptr_next = rptr + PW'(1);

  assign consume = read_valid & read_ready;
  assign load    = (mem_count != '0) & (~read_valid | consume);

  assign ram_address  = rptr[ADDRESS_WIDTH-1:0];
  assign level        = LW'(mem_count) + LW'(read_valid);
  assign empty        = ~read_valid;
  assign almost_empty = (level <= LW'(ALMOST_EMPTY_THRESHOLD));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr              <= '0;
      read_pointer_gray <= '0;
      read_data         <= '0;
      read_valid        <= 1'b0;
      protocol_error    <= 1'b0;
    end else begin
      if (mem_count > DEPTH) begin
        protocol_error <= 1'b1;
      end
      if (load) begin
        read_data         <= ram_data;
        rptr              <= rptr_next;
        read_pointer_gray <= rptr_next ^ (rptr_next >> 1);
        read_valid        <= 1'b1;
      end else if (consume) begin
        read_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdc_fifo_read_ctrl.sv
// Directed-vector bench for cdc_fifo_read_ctrl.
// A bench-side RAM and writer model feed the read controller.
module tb_cdc_fifo_read_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] write_pointer_gray;
  logic [4:0] read_pointer_gray;
  logic [3:0] ram_address;
  logic [7:0] ram_data;
  logic [7:0] read_data;
  logic       read_valid;
  logic       read_ready;
  logic       empty;
  logic       almost_empty;
  logic [5:0] level;
  logic       protocol_error;

  logic [7:0] ram [16];
  int nvec = 0;
  int nerr = 0;

  cdc_fifo_read_ctrl #(
    .DATA_WIDTH(8),
    .ADDRESS_WIDTH(4),
    .SYNC_STAGES(2),
    .ALMOST_EMPTY_THRESHOLD(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .write_pointer_gray(write_pointer_gray),
    .read_pointer_gray(read_pointer_gray),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .read_data(read_data),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .empty(empty),
    .almost_empty(almost_empty),
    .level(level),
    .protocol_error(protocol_error)
  );

  assign ram_data = ram[ram_address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] x);
    logic [4:0] b;
    b[4] = x[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ x[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write_pointer_gray = '0;
    read_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write_pointer_gray = g(3);
    read_ready = 1'b1;
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'h50 + i);
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if (read_valid !== 1'b0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
        level !== 6'd0 || read_pointer_gray !== 5'd0 || protocol_error !== 1'b0) begin
      nerr++;
      $display("FAIL reset: valid=%b empty=%b ae=%b level=%0d rpg=%h perr=%b, want 0 1 1 0 0 0",
               read_valid, empty, almost_empty, level, read_pointer_gray, protocol_error);
    end
    write_pointer_gray = '0;
    read_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_word();
    do_reset();
    ram[0] = 8'hA5;
    write_pointer_gray = g(1);
    tick();
    nvec++;
    if (read_valid !== 1'b0) begin
      nerr++;
      $display("FAIL latency_clk1: valid=%b want 0", read_valid);
    end
    tick();
    nvec++;
    if (read_valid !== 1'b0) begin
      nerr++;
      $display("FAIL latency_clk2: valid=%b want 0", read_valid);
    end
    tick();
    nvec++;
    if (read_valid !== 1'b1 || read_data !== 8'hA5 ||
        read_pointer_gray !== 5'd1 || level !== 6'd1) begin
      nerr++;
      $display("FAIL first_word: valid=%b data=%h rpg=%h level=%0d, want 1 a5 01 1",
               read_valid, read_data, read_pointer_gray, level);
    end
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    nvec++;
    if (read_valid !== 1'b0 || empty !== 1'b1 || read_data !== 8'hA5) begin
      nerr++;
      $display("FAIL drain: valid=%b empty=%b data=%h, want 0 1 a5",
               read_valid, empty, read_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'h30 + i);
    write_pointer_gray = g(16);
    repeat (3) tick();
    nvec++;
    if (read_valid !== 1'b1 || read_data !== 8'h30 || ram_address !== 4'd1 ||
        read_pointer_gray !== 5'd1 || level !== 6'd16) begin
      nerr++;
      $display("FAIL fill: valid=%b data=%h addr=%0d rpg=%h level=%0d, want 1 30 1 01 16",
               read_valid, read_data, ram_address, read_pointer_gray, level);
    end
    repeat (50) tick();
    nvec++;
    if (read_valid !== 1'b1 || read_data !== 8'h30 || ram_address !== 4'd1 ||
        read_pointer_gray !== 5'd1 || level !== 6'd16 || protocol_error !== 1'b0) begin
      nerr++;
      $display("FAIL hold: valid=%b data=%h addr=%0d rpg=%h level=%0d perr=%b, want 1 30 1 01 16 0",
               read_valid, read_data, ram_address, read_pointer_gray, level, protocol_error);
    end
  endtask

  task automatic test_streaming();
    int w;
    int exp;
    int wraps;
    int cyc;
    logic v;
    logic [3:0] pa;
    logic [4:0] occ;
    do_reset();
    w = 0;
    exp = 0;
    wraps = 0;
    cyc = 0;
    read_ready = 1'b1;
    while (exp < 40 && cyc < 200) begin
      occ = 5'(w) - g2b(read_pointer_gray);
      if (w < 40 && occ < 5'd16) begin
        ram[w % 16] = 8'(w);
        write_pointer_gray = g(w + 1);
        w++;
      end
      v = read_valid;
      pa = ram_address;
      tick();
      cyc++;
      if (pa == 4'd15 && ram_address == 4'd0) wraps++;
      if (v) exp++;
      if (read_valid) begin
        nvec++;
        if (read_data !== 8'(exp)) begin
          nerr++;
          $display("FAIL stream_data: got %h want %h", read_data, 8'(exp));
        end
      end
    end
    read_ready = 1'b0;
    nvec++;
    if (exp != 40 || cyc != 43) begin
      nerr++;
      $display("FAIL stream_rate: words=%0d cycles=%0d, want 40 43", exp, cyc);
    end
    nvec++;
    if (wraps != 2) begin
      nerr++;
      $display("FAIL addr_wrap: wraps=%0d want 2", wraps);
    end
    nvec++;
    if (read_pointer_gray !== g(40) || empty !== 1'b1) begin
      nerr++;
      $display("FAIL stream_end: rpg=%h empty=%b, want %h 1",
               read_pointer_gray, empty, g(40));
    end
  endtask

  task automatic test_thresholds();
    logic [5:0] lv [4];
    logic       ae [4];
    logic       em [4];
    lv = '{6'd3, 6'd2, 6'd1, 6'd0};
    ae = '{1'b0, 1'b1, 1'b1, 1'b1};
    em = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    write_pointer_gray = g(4);
    repeat (3) tick();
    nvec++;
    if (level !== 6'd4 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      nerr++;
      $display("FAIL thr_level4: level=%0d ae=%b empty=%b, want 4 0 0",
               level, almost_empty, empty);
    end
    for (int i = 0; i < 4; i++) begin
      read_ready = 1'b1;
      tick();
      read_ready = 1'b0;
      nvec++;
      if (level !== lv[i] || almost_empty !== ae[i] || empty !== em[i]) begin
        nerr++;
        $display("FAIL thr_step%0d: level=%0d ae=%b empty=%b, want %0d %b %b",
                 i, level, almost_empty, empty, lv[i], ae[i], em[i]);
      end
    end
  endtask

  task automatic test_error_recovery();
    do_reset();
    write_pointer_gray = g(20);
    repeat (3) tick();
    nvec++;
    if (protocol_error !== 1'b1) begin
      nerr++;
      $display("FAIL perr_set: perr=%b want 1", protocol_error);
    end
    write_pointer_gray = g(5);
    repeat (5) tick();
    nvec++;
    if (protocol_error !== 1'b1 || read_valid !== 1'b1) begin
      nerr++;
      $display("FAIL perr_sticky: perr=%b valid=%b, want 1 1", protocol_error, read_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if (read_valid !== 1'b0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
        level !== 6'd0 || read_pointer_gray !== 5'd0 || protocol_error !== 1'b0 ||
        read_data !== 8'h00 || ram_address !== 4'd0) begin
      nerr++;
      $display("FAIL mid_reset: valid=%b empty=%b ae=%b level=%0d rpg=%h perr=%b data=%h addr=%0d",
               read_valid, empty, almost_empty, level, read_pointer_gray,
               protocol_error, read_data, ram_address);
    end
    write_pointer_gray = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    write_pointer_gray = '0;
    read_ready = 1'b0;
    test_reset();
    test_first_word();
    test_backpressure();
    test_streaming();
    test_thresholds();
    test_error_recovery();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
